// File: rtl/regfile_sb.sv
// Register file with a per-register busy scoreboard, optional zero register,
// optional write-to-read forwarding and a sequential soft-clear engine.
module regfile_sb #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NREG     = 32,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1,
    localparam int unsigned AW      = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   ra1,
    input  logic [AW-1:0]   ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    output logic            busy1,
    output logic            busy2,
    input  logic            we,
    input  logic [AW-1:0]   wa,
    input  logic [XLEN-1:0] wd,
    input  logic            rsv_en,
    input  logic [AW-1:0]   rsv_addr,
    input  logic            clr_req,
    output logic            clr_busy,
    output logic            clr_done
);

    typedef enum logic {StIdle, StClear} state_e;

    localparam logic [AW-1:0] FirstIdx = ZERO_REG ? AW'(1) : '0;
    localparam logic [AW-1:0] LastIdx  = AW'(NREG - 1);

    state_e          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic            done_q, done_d;
    logic [XLEN-1:0] regs_q [NREG];
    logic [NREG-1:0] busy_q, busy_d;

    logic wr_ok, rsv_ok, fwd1, fwd2;

    assign clr_busy = (state_q == StClear);
    assign clr_done = done_q;

    // Register 0 is hardwired when ZERO_REG, so writes and reserves to it are suppressed.
    assign wr_ok  = we && !clr_busy && !(ZERO_REG && (wa == '0));
    assign rsv_ok = rsv_en && !clr_busy && !(ZERO_REG && (rsv_addr == '0));

    assign fwd1 = BYPASS && wr_ok && (wa == ra1);
    assign fwd2 = BYPASS && wr_ok && (wa == ra2);

    assign rd1   = (ZERO_REG && (ra1 == '0)) ? '0 : (fwd1 ? wd : regs_q[ra1]);
    assign rd2   = (ZERO_REG && (ra2 == '0)) ? '0 : (fwd2 ? wd : regs_q[ra2]);
    assign busy1 = !fwd1 && busy_q[ra1];
    assign busy2 = !fwd2 && busy_q[ra2];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (clr_req) begin
                    state_d = StClear;
                    cnt_d   = FirstIdx;
                end
            end
            StClear: begin
                cnt_d = cnt_q + AW'(1);
                if (cnt_q == LastIdx) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Reserve is applied after the write release so a new producer keeps the bit set.
    always_comb begin
        busy_d = busy_q;
        if (clr_busy) begin
            busy_d[cnt_q] = 1'b0;
        end else begin
            if (wr_ok) busy_d[wa] = 1'b0;
            if (rsv_ok) busy_d[rsv_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(NREG); i++) regs_q[i] <= '0;
        end else if (clr_busy) begin
            regs_q[cnt_q] <= '0;
        end else if (wr_ok) begin
            regs_q[wa] <= wd;
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench: two DUT configurations share one stimulus stream and are
// checked against an array-based reference model every cycle.
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic        we, rsv_en, clr_req;
    logic [4:0]  wa, ra1, ra2, rsv_addr;
    logic [63:0] wd;

    logic [31:0] a_rd1, a_rd2;
    logic        a_busy1, a_busy2, a_cb, a_cd;
    logic [63:0] b_rd1, b_rd2;
    logic        b_busy1, b_busy2, b_cb, b_cd;

    always #5 clk = ~clk;

    regfile_sb u_a (
        .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rd1(a_rd1), .rd2(a_rd2),
        .busy1(a_busy1), .busy2(a_busy2), .we(we), .wa(wa), .wd(wd[31:0]),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .clr_req(clr_req),
        .clr_busy(a_cb), .clr_done(a_cd)
    );

    regfile_sb #(.XLEN(64), .NREG(8), .ZERO_REG(1'b0), .BYPASS(1'b0)) u_b (
        .clk(clk), .rst(rst), .ra1(ra1[2:0]), .ra2(ra2[2:0]), .rd1(b_rd1), .rd2(b_rd2),
        .busy1(b_busy1), .busy2(b_busy2), .we(we), .wa(wa[2:0]), .wd(wd),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr[2:0]), .clr_req(clr_req),
        .clr_busy(b_cb), .clr_done(b_cd)
    );

    typedef struct {
        logic [63:0] rd1, rd2;
        bit          busy1, busy2, cb, cd;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Reference model: index 0 = default config, index 1 = 64-bit/8-reg/no-zero/no-bypass.
    logic [63:0] m_reg  [2][32];
    bit          m_busy [2][32];
    bit          m_clr  [2];
    int          m_pos  [2];
    bit          m_done [2];

    function automatic int nreg(int d); return (d == 0) ? 32 : 8; endfunction
    function automatic bit zr(int d); return d == 0; endfunction
    function automatic bit byp(int d); return d == 0; endfunction
    function automatic logic [63:0] mask(int d);
        return (d == 0) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
    endfunction

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 32; i++) begin
                m_reg[d][i]  = '0;
                m_busy[d][i] = 1'b0;
            end
            m_clr[d]  = 1'b0;
            m_pos[d]  = 0;
            m_done[d] = 1'b0;
        end
    endfunction

    function automatic exp_t predict(int d);
        exp_t e;
        int   n   = nreg(d);
        int   a   = int'(wa) % n;
        int   r1  = int'(ra1) % n;
        int   r2  = int'(ra2) % n;
        bit   wok = we && !m_clr[d] && !(zr(d) && a == 0);
        bit   f1  = byp(d) && wok && (a == r1);
        bit   f2  = byp(d) && wok && (a == r2);
        e.rd1   = (zr(d) && r1 == 0) ? 64'd0 : (f1 ? (wd & mask(d)) : m_reg[d][r1]);
        e.rd2   = (zr(d) && r2 == 0) ? 64'd0 : (f2 ? (wd & mask(d)) : m_reg[d][r2]);
        e.busy1 = f1 ? 1'b0 : m_busy[d][r1];
        e.busy2 = f2 ? 1'b0 : m_busy[d][r2];
        e.cb    = m_clr[d];
        e.cd    = m_done[d];
        return e;
    endfunction

    function automatic void model_edge(int d);
        int n  = nreg(d);
        int a  = int'(wa) % n;
        int ra = int'(rsv_addr) % n;
        if (m_clr[d]) begin
            m_reg[d][m_pos[d]]  = '0;
            m_busy[d][m_pos[d]] = 1'b0;
            m_pos[d]++;
            m_done[d] = (m_pos[d] == n);
            if (m_done[d]) m_clr[d] = 1'b0;
        end else begin
            m_done[d] = 1'b0;
            if (we && !(zr(d) && a == 0)) begin
                m_reg[d][a]  = wd & mask(d);
                m_busy[d][a] = 1'b0;
            end
            if (rsv_en && !(zr(d) && ra == 0)) m_busy[d][ra] = 1'b1;
            if (clr_req) begin
                m_clr[d] = 1'b1;
                m_pos[d] = zr(d) ? 1 : 0;
            end
        end
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h, expected %h", nm, $time, act, exp);
        end
    endtask

    // Monitor: one expectation per cycle, sampled mid-cycle on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (qa.size() > 0 && qb.size() > 0) begin
                exp_t ea, eb;
                ea = qa.pop_front();
                eb = qb.pop_front();
                chk("a.rd1", {32'd0, a_rd1}, ea.rd1);
                chk("a.rd2", {32'd0, a_rd2}, ea.rd2);
                chk("a.busy1", 64'(a_busy1), 64'(ea.busy1));
                chk("a.busy2", 64'(a_busy2), 64'(ea.busy2));
                chk("a.clr_busy", 64'(a_cb), 64'(ea.cb));
                chk("a.clr_done", 64'(a_cd), 64'(ea.cd));
                chk("b.rd1", b_rd1, eb.rd1);
                chk("b.rd2", b_rd2, eb.rd2);
                chk("b.busy1", 64'(b_busy1), 64'(eb.busy1));
                chk("b.busy2", 64'(b_busy2), 64'(eb.busy2));
                chk("b.clr_busy", 64'(b_cb), 64'(eb.cb));
                chk("b.clr_done", 64'(b_cd), 64'(eb.cd));
            end
        end
    end

    // Called just after a rising edge: drive inputs, queue expectations, advance one edge.
    task automatic step(input bit i_we, input int i_wa, input logic [63:0] i_wd,
                        input int i_ra1, input int i_ra2, input bit i_rsv, input int i_rsa,
                        input bit i_clr);
        we       = i_we;
        wa       = 5'(i_wa);
        wd       = i_wd;
        ra1      = 5'(i_ra1);
        ra2      = 5'(i_ra2);
        rsv_en   = i_rsv;
        rsv_addr = 5'(i_rsa);
        clr_req  = i_clr;
        qa.push_back(predict(0));
        qb.push_back(predict(1));
        @(posedge clk);
        #1;
        if (rst) begin
            model_edge(0);
            model_edge(1);
        end
    endtask

    task automatic idle(input int ra_a, input int ra_b);
        step(1'b0, 0, 64'd0, ra_a, ra_b, 1'b0, 0, 1'b0);
    endtask

    task automatic fill_random();
        for (int i = 0; i < 32; i++) step(1'b1, i, {$urandom, $urandom}, i, 31 - i, 1'b0, 0, 1'b0);
    endtask

    task automatic read_all();
        for (int i = 0; i < 32; i += 2) idle(i, i + 1);
    endtask

    initial begin
        rst = 1'b0;
        we = 1'b0; wa = '0; wd = '0; ra1 = '0; ra2 = '0;
        rsv_en = 1'b0; rsv_addr = '0; clr_req = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        idle(5, 9);
        idle(0, 31);
        rst = 1'b1;

        // Write then read, zero register, bypass.
        step(1'b1, 5, 64'hDEAD_BEEF, 1, 2, 1'b0, 0, 1'b0);
        idle(5, 0);
        step(1'b1, 0, 64'h1234, 0, 5, 1'b0, 0, 1'b0);
        idle(0, 5);
        step(1'b1, 7, 64'h1111_2222_3333_4444, 3, 7, 1'b0, 0, 1'b0);
        step(1'b1, 7, 64'hA5A5_A5A5_A5A5_A5A5, 3, 7, 1'b0, 0, 1'b0);
        idle(7, 7);

        // Scoreboard: reserve, release by write, same-cycle reserve + write.
        step(1'b0, 0, 64'd0, 9, 9, 1'b1, 9, 1'b0);
        idle(9, 1);
        step(1'b1, 9, 64'h99, 9, 2, 1'b0, 0, 1'b0);
        idle(9, 1);
        step(1'b1, 9, 64'h9999, 9, 9, 1'b1, 9, 1'b0);
        idle(9, 9);
        step(1'b0, 0, 64'd0, 0, 0, 1'b1, 0, 1'b0);
        idle(0, 8);

        // Soft clear with a dropped write and reserve inside the window.
        fill_random();
        step(1'b0, 0, 64'd0, 3, 4, 1'b1, 6, 1'b1);
        for (int i = 0; i < 36; i++) begin
            if (i == 4) step(1'b1, 3, 64'hCAFE_F00D, 3, 2, 1'b1, 3, 1'b1);
            else idle(i % 32, 3);
        end
        read_all();

        // Asynchronous reset part-way through a clear.
        fill_random();
        step(1'b0, 0, 64'd0, 1, 2, 1'b0, 0, 1'b1);
        for (int i = 0; i < 10; i++) idle(30, 31);
        #1;
        rst = 1'b0;
        model_reset();
        idle(30, 31);
        idle(29, 4);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) idle(28, 27);
        read_all();

        // clr_req held high restarts right after each done pulse.
        fill_random();
        for (int i = 0; i < 70; i++) step(1'b1, i % 32, 64'(i + 1), i % 32, 2, 1'b0, 0, 1'b1);
        for (int i = 0; i < 35; i++) idle(i % 32, 5);

        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 3) != 0), $urandom_range(0, 31), {$urandom, $urandom},
                 $urandom_range(0, 31), $urandom_range(0, 31), ($urandom_range(0, 2) == 0),
                 $urandom_range(0, 31), ($urandom_range(0, 60) == 0));
        end

        @(negedge clk);
        #1;
        n_vec++;
        if (qa.size() != 0 || qb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d/%0d expectations left, expected 0", qa.size(), qb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
